// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer pipeline: widths, ALU select codes,
// forwarding-source select and the ID/EX register layout.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned SEL_W = 6;

  localparam logic [SEL_W-1:0] ALU_NOP  = 6'b000000;
  localparam logic [SEL_W-1:0] ALU_ADD  = 6'b011100;
  localparam logic [SEL_W-1:0] ALU_ADDI = 6'b010011;

  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [RA_W-1:0]  rs1_addr;
    logic [RA_W-1:0]  rs2_addr;
    logic [RA_W-1:0]  rd_addr;
    logic [SEL_W-1:0] alu_select;
    logic             use_imm;
    logic             reg_write;
    logic             mem_read;
  } ex_regs_t;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic fwd_hit(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rd,
                                   input logic we);
    return we && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Single-operand forwarding: picks MEM, then WB, then stored regfile data.
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (fwd_hit(rs_addr, mem_rd_addr, mem_reg_write)) begin
      sel = FWD_MEM;
    end else if (fwd_hit(rs_addr, wb_rd_addr, wb_reg_write)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    fwd_data = reg_data;
    unique case (sel)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_result;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble
// insertion, feeding the ALU operands and select.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall_in,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1_addr,
  input  logic [RA_W-1:0]  id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic [SEL_W-1:0] id_alu_select,
  input  logic             id_use_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [RA_W-1:0]  mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic [XLEN-1:0]  wb_result,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [SEL_W-1:0] ex_alu_select,
  output logic [XLEN-1:0]  ex_pc,
  output logic [RA_W-1:0]  ex_rd_addr,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_valid,
  output logic             load_use_stall
);

  ex_regs_t ex_q, ex_d, bubble;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  fwd_unit u_fwd_rs1 (
    .rs_addr       (ex_q.rs1_addr),
    .reg_data      (ex_q.rs1_data),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs1)
  );

  fwd_unit u_fwd_rs2 (
    .rs_addr       (ex_q.rs2_addr),
    .reg_data      (ex_q.rs2_data),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs2)
  );

  always_comb begin
    load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && id_valid &&
                     ((id_rs1_used && (ex_q.rd_addr == id_rs1_addr)) ||
                      (id_rs2_used && (ex_q.rd_addr == id_rs2_addr)));
    id_ready = !load_use_stall && !stall_in;
  end

  always_comb begin
    bubble            = '0;
    bubble.alu_select = ALU_NOP;

    ex_d = ex_q;
    if (flush) begin
      ex_d = bubble;
    end else if (stall_in) begin
      // Latch forwarded values so a producer retiring from WB mid-hold is not lost.
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (load_use_stall) begin
      ex_d = bubble;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.pc         = id_pc;
      ex_d.rs1_data   = id_rs1_data;
      ex_d.rs2_data   = id_rs2_data;
      ex_d.imm        = id_imm;
      ex_d.rs1_addr   = id_rs1_addr;
      ex_d.rs2_addr   = id_rs2_addr;
      ex_d.rd_addr    = id_rd_addr;
      ex_d.alu_select = id_alu_select;
      ex_d.use_imm    = id_use_imm;
      ex_d.reg_write  = id_reg_write && id_valid;
      ex_d.mem_read   = id_mem_read && id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_comb begin
    ex_a          = fwd_rs1;
    ex_b          = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    ex_store_data = fwd_rs2;
    ex_alu_select = ex_q.alu_select;
    ex_pc         = ex_q.pc;
    ex_rd_addr    = ex_q.rd_addr;
    ex_reg_write  = ex_q.reg_write;
    ex_mem_read   = ex_q.mem_read;
    ex_valid      = ex_q.valid;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued as each ID
// instruction is driven and compared once it reaches EX.
module tb_id_ex_stage;

  localparam logic [5:0] SEL_NOP  = 6'b000000;
  localparam logic [5:0] SEL_ADD  = 6'b011100;
  localparam logic [5:0] SEL_ADDI = 6'b010011;

  logic        clk, rst_n, flush, stall_in, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used, id_use_imm, id_reg_write, id_mem_read;
  logic [5:0]  id_alu_select;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [5:0]  ex_alu_select;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_valid, load_use_stall;

  typedef struct {
    string       tag;
    logic        data_chk;
    logic [31:0] a, b, sd, pc;
    logic [5:0]  sel;
    logic [4:0]  rd;
    logic        rw, mr, valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall_in(stall_in),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
    .id_alu_select(id_alu_select), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_alu_select(ex_alu_select), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] a1,
                        input logic [4:0] a2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic [5:0] sel, input logic ui,
                        input logic rw, input logic mr);
    id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_rs1_addr = a1; id_rs2_addr = a2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd_addr = rd; id_alu_select = sel; id_use_imm = ui;
    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic push(input string tag, input logic dc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] sd, input logic [31:0] pc,
                      input logic [5:0] sel, input logic [4:0] rd, input logic rw,
                      input logic mr, input logic v);
    exp_t e;
    e.tag = tag; e.data_chk = dc; e.a = a; e.b = b; e.sd = sd; e.pc = pc;
    e.sel = sel; e.rd = rd; e.rw = rw; e.mr = mr; e.valid = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ex();
    exp_t e;
    n_checks++;
    assert (exp_q.size() != 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_valid"}, {31'b0, ex_valid}, {31'b0, e.valid});
      chk({e.tag, "_reg_write"}, {31'b0, ex_reg_write}, {31'b0, e.rw});
      chk({e.tag, "_mem_read"}, {31'b0, ex_mem_read}, {31'b0, e.mr});
      chk({e.tag, "_sel"}, {26'b0, ex_alu_select}, {26'b0, e.sel});
      if (e.data_chk) begin
        chk({e.tag, "_a"}, ex_a, e.a);
        chk({e.tag, "_b"}, ex_b, e.b);
        chk({e.tag, "_store"}, ex_store_data, e.sd);
        chk({e.tag, "_pc"}, ex_pc, e.pc);
        chk({e.tag, "_rd"}, {27'b0, ex_rd_addr}, {27'b0, e.rd});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                     input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mw; mem_rd_addr = mrd; mem_result = mres;
    wb_reg_write = ww; wb_rd_addr = wrd; wb_result = wres;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, ex_a, 32'h0);
    chk({tag, "_b"}, ex_b, 32'h0);
    chk({tag, "_store"}, ex_store_data, 32'h0);
    chk({tag, "_pc"}, ex_pc, 32'h0);
    chk({tag, "_sel"}, {26'b0, ex_alu_select}, {26'b0, SEL_NOP});
    chk({tag, "_rd"}, {27'b0, ex_rd_addr}, 32'h0);
    chk({tag, "_ctrl"}, {29'b0, ex_valid, ex_reg_write, ex_mem_read}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall_in = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SEL_NOP, 0, 0, 0);
    fwd(0, 0, 0, 0, 0, 0);
    #1;
    chk_all_zero("reset_init");
    tick(); tick();
    #2 rst_n = 1'b1;

    // ADDI x5, x1, 7 with rs1 data 10
    set_id(1, 32'h100, 32'd10, 32'h0, 32'd7, 5'd1, 5'd0, 1, 0, 5'd5, SEL_ADDI, 1, 1, 0);
    push("addi", 1, 32'd10, 32'd7, 32'h0, 32'h100, SEL_ADDI, 5'd5, 1, 0, 1);
    tick();
    check_ex();

    // ADD x8, x3, x0: MEM beats WB, WB beats regfile
    set_id(1, 32'h104, 32'h99, 32'h5, 32'h0, 5'd3, 5'd0, 1, 1, 5'd8, SEL_ADD, 0, 1, 0);
    push("add_x3", 1, 32'h99, 32'h5, 32'h5, 32'h104, SEL_ADD, 5'd8, 1, 0, 1);
    tick();
    check_ex();
    fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    #1 chk("fwd_mem_over_wb", ex_a, 32'h11);
    chk("fwd_x0_rs2_not_forwarded", ex_b, 32'h5);
    mem_reg_write = 1'b0;
    #1 chk("fwd_wb", ex_a, 32'h22);
    fwd(0, 0, 0, 0, 0, 0);
    #1 chk("fwd_none", ex_a, 32'h99);

    // rs1 = x0 with MEM/WB writing x0
    set_id(1, 32'h108, 32'h77, 32'h0, 32'd1, 5'd0, 5'd0, 1, 0, 5'd9, SEL_ADDI, 1, 1, 0);
    push("x0_rs1", 1, 32'h77, 32'd1, 32'h0, 32'h108, SEL_ADDI, 5'd9, 1, 0, 1);
    tick();
    fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    #1 check_ex();
    fwd(0, 0, 0, 0, 0, 0);

    // Load-use: LW x4 in EX, ADD x6, x4, x2 in ID
    set_id(1, 32'h10c, 32'h200, 32'h0, 32'h0, 5'd1, 5'd0, 1, 0, 5'd4, SEL_ADDI, 1, 1, 1);
    push("lw", 1, 32'h200, 32'h0, 32'h0, 32'h10c, SEL_ADDI, 5'd4, 1, 1, 1);
    tick();
    check_ex();
    set_id(1, 32'h110, 32'h0, 32'h3, 32'h0, 5'd4, 5'd2, 1, 1, 5'd6, SEL_ADD, 0, 1, 0);
    #1 chk("lu_stall", {31'b0, load_use_stall}, 32'd1);
    chk("lu_id_ready", {31'b0, id_ready}, 32'd0);
    push("lu_bubble", 0, 0, 0, 0, 0, SEL_NOP, 0, 0, 0, 0);
    tick();
    fwd(1, 5'd4, 32'h200, 0, 0, 0);
    #1 check_ex();
    chk("lu_stall_clear", {31'b0, load_use_stall}, 32'd0);
    chk("lu_id_ready_back", {31'b0, id_ready}, 32'd1);
    push("lu_add", 1, 32'habc, 32'h3, 32'h3, 32'h110, SEL_ADD, 5'd6, 1, 0, 1);
    tick();
    fwd(0, 0, 0, 1, 5'd4, 32'habc);
    #1 check_ex();
    fwd(0, 0, 0, 0, 0, 0);

    // stall_in for 3 cycles while WB retires x7 = 0x55 (rs2)
    set_id(1, 32'h114, 32'h1, 32'h0, 32'h0, 5'd1, 5'd7, 1, 1, 5'd9, SEL_ADD, 0, 1, 0);
    push("stall_add", 1, 32'h1, 32'h55, 32'h55, 32'h114, SEL_ADD, 5'd9, 1, 0, 1);
    tick();
    fwd(0, 0, 0, 1, 5'd7, 32'h55);
    stall_in = 1'b1;
    set_id(1, 32'h118, 32'h0, 32'h0, 32'd3, 5'd2, 5'd0, 1, 0, 5'd10, SEL_ADDI, 1, 1, 0);
    #1 check_ex();
    chk("stall_id_ready", {31'b0, id_ready}, 32'd0);
    tick();
    fwd(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("stall_hold_b_%0d", i), ex_b, 32'h55);
      chk($sformatf("stall_hold_rd_%0d", i), {27'b0, ex_rd_addr}, 32'd9);
      if (i < 2) tick();
    end
    stall_in = 1'b0;

    // flush + stall_in + load-use together
    set_id(1, 32'h11c, 32'h300, 32'h0, 32'h0, 5'd1, 5'd0, 1, 0, 5'd4, SEL_ADDI, 1, 1, 1);
    push("lw2", 1, 32'h300, 32'h0, 32'h0, 32'h11c, SEL_ADDI, 5'd4, 1, 1, 1);
    tick();
    check_ex();
    set_id(1, 32'h120, 32'h0, 32'h3, 32'h0, 5'd4, 5'd2, 1, 1, 5'd6, SEL_ADD, 0, 1, 0);
    stall_in = 1'b1; flush = 1'b1;
    #1 chk("combo_lu", {31'b0, load_use_stall}, 32'd1);
    push("combo_bubble", 0, 0, 0, 0, 0, SEL_NOP, 0, 0, 0, 0);
    tick();
    stall_in = 1'b0; flush = 1'b0;
    check_ex();

    // Reset mid-run, then capture on first edge after release
    set_id(1, 32'h200, 32'h44, 32'h0, 32'h8, 5'd1, 5'd0, 1, 0, 5'd11, SEL_ADDI, 1, 1, 0);
    push("pre_reset", 1, 32'h44, 32'h8, 32'h0, 32'h200, SEL_ADDI, 5'd11, 1, 0, 1);
    tick();
    check_ex();
    rst_n = 1'b0;
    #1 chk_all_zero("reset_mid");
    #2 rst_n = 1'b1;
    set_id(1, 32'h300, 32'h5, 32'h0, 32'd7, 5'd1, 5'd0, 1, 0, 5'd5, SEL_ADDI, 1, 1, 0);
    push("post_reset", 1, 32'h5, 32'd7, 32'h0, 32'h300, SEL_ADDI, 5'd5, 1, 0, 1);
    tick();
    check_ex();

    n_checks++;
    assert (exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
